vga_frame_capture: RTL and testbench
====================================

Name: vga_frame_capture

Overview:
- VGA sink: the receiving end of the 8-bit TinyTapeout VGA PMOD bus that the Game-of-Life top drives on uo_out.
- Recovers pixel and line position from hsync/vsync and checks line and frame timing.
- Samples the centre pixel of every 8x8 cell in the 32x16 board window into a bitmap, and counts live cells.
- Used as the on-chip/bench checker for the display path, and for loopback of a second board.

Parameters:
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_OFFSET, 144, h_cnt value at which registered RGB corresponds to active column 0
- V_OFFSET, 35, v_cnt value corresponding to active row 0
- X0, 64, first board column (pixels)
- Y0, 112, first board row (pixels)
- SAMPLE_OFS, 3, sample offset inside each 8x8 cell, both axes
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low-active

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vga_in  in  8  {hsync, B0, G0, R0, vsync, B1, G1, R1}, PMOD ordering
- rd_addr  in  9  committed-bitmap address = cy*32 + cx
- rd_data  out  1  committed bitmap bit at rd_addr (combinational)
- live_count  out  10  live cells in last committed frame
- frame_cnt  out  16  committed frames, wraps at 65535->0
- frame_valid  out  1  one-cycle pulse when a frame is committed
- frame_drop  out  1  one-cycle pulse when a captured frame is discarded
- locked  out  1  high while state == CAPTURE
- timing_err  out  1  sticky line-length error flag

Behaviour:
- Reset (async): all outputs 0; state SEARCH; both bitmaps, counters and input register cleared.
- Input stage:
  - vga_in registered once; syncs normalised to active-high per SYNC_ACTIVE_LOW.
  - hs_edge/vs_edge = registered sync high and its previous value low.
- h_cnt (10 b):
  - 0 on the hs_edge cycle, else +1, saturating at 1023.
  - On hs_edge, line_err = (h_cnt != H_TOTAL-1); not evaluated in SEARCH.
- v_cnt (10 b):
  - vs_edge sets vs_pending.
  - On hs_edge: if vs_pending, v_cnt <= 0 and vs_pending cleared; else v_cnt +1, saturating.
- Sample point:
  - h_cnt == H_OFFSET + X0 + 8*cx + SAMPLE_OFS and v_cnt == V_OFFSET + Y0 + 8*cy + SAMPLE_OFS, cx 0..31, cy 0..15.
  - Cell bit = R1 & G1 (vga_in[0] & vga_in[1], registered).
  - Written to the shadow bitmap at cy*32+cx; live_acc increments when the bit is 1.
- State machine:
  - SEARCH -> ALIGN on the first vs_edge.
  - ALIGN -> CAPTURE on the next vs_edge if no line_err occurred and v_cnt == V_TOTAL-1 at that edge; otherwise stay in ALIGN and re-measure.
  - CAPTURE + line_err -> SEARCH in the cycle after the hs_edge; timing_err <= 1 and held until reset; current frame discarded with no frame_drop pulse.
- Commit, on vs_edge while in CAPTURE:
  - If v_cnt == V_TOTAL-1: shadow copied to the committed bitmap, live_count <= live_acc, frame_cnt +1, frame_valid pulses in the cycle after vs_edge.
  - Otherwise frame_drop pulses; committed bitmap, live_count and frame_cnt unchanged.
  - In every case live_acc and the shadow are cleared for the next frame.
- The committed bitmap changes only at commit; rd_data is stable between commits.
- Simultaneous hs_edge and vs_edge: the commit check uses the pre-edge v_cnt, then vs_pending is applied.
- Counts saturate: lines never wrap h_cnt/v_cnt. A missing sync saturates the counter, which then fails the equality check.

Test Plan:
- Reset asserted with vga_in toggling -> all outputs 0, locked=0; after reset release and before any vsync edge, outputs stay 0.
- Standard 640x480 model drives board cells (0,0), (5,7), (31,15) live for 3 frames -> locked=1 after the 2nd vs_edge. After the 3rd, frame_valid pulses once and frame_cnt=1, live_count=3, and rd_data=1 at addresses 0, 229 and 511; 0 at all 509 other addresses.
- In CAPTURE, one line shortened to 799 clocks -> locked=0 the cycle after that hs_edge, timing_err=1 until reset, no frame_valid for that frame, relock after 2 clean vs_edges.
- Locked, one frame with 524 lines -> frame_drop pulses once; live_count, frame_cnt and bitmap keep their previous values; the next good frame commits normally.
- reset pulsed mid-frame in CAPTURE -> outputs immediately 0 and timing_err cleared; state SEARCH, requiring 2 vs_edges to relock.
- SYNC_ACTIVE_LOW=0 with inverted sync polarity, same pattern as scenario 2 -> identical bitmap, live_count=3.

Source files
------------

// File: rtl/vga_frame_capture.sv
// VGA sink: recovers raster position from the PMOD syncs, checks line/frame timing and
// samples one pixel per 8x8 board cell into a double-buffered 32x16 bitmap.
module vga_frame_capture #(
    parameter int unsigned H_TOTAL         = 800,
    parameter int unsigned V_TOTAL         = 525,
    parameter int unsigned H_OFFSET        = 144,
    parameter int unsigned V_OFFSET        = 35,
    parameter int unsigned X0              = 64,
    parameter int unsigned Y0              = 112,
    parameter int unsigned SAMPLE_OFS      = 3,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    input  logic [8:0]  rd_addr,
    output logic        rd_data,
    output logic [9:0]  live_count,
    output logic [15:0] frame_cnt,
    output logic        frame_valid,
    output logic        frame_drop,
    output logic        locked,
    output logic        timing_err
);

    typedef enum logic [1:0] {StSearch, StAlign, StCapture} state_e;

    localparam logic       SyncInv = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HStart  = 10'(H_OFFSET + X0);
    localparam logic [9:0] VStart  = 10'(V_OFFSET + Y0);
    localparam logic [2:0] SubOfs  = 3'(SAMPLE_OFS);

    logic         r_hs, r_vs, r_hs_prev, r_vs_prev;
    logic [1:0]   r_pix;
    logic [9:0]   r_h_cnt, r_v_cnt;
    logic         r_vs_pending;
    state_e       r_state, w_state_d;
    logic         r_align_err;
    logic [511:0] r_shadow, r_bitmap;
    logic [9:0]   r_live_acc, r_live_count;
    logic [15:0]  r_frame_cnt;
    logic         r_frame_valid, r_frame_drop, r_timing_err;

    logic         w_hs_edge, w_vs_edge, w_vs_pend, w_line_err, w_v_last;
    logic         w_commit, w_drop, w_abort;
    logic [9:0]   w_hx, w_vy;
    logic         w_sample, w_bit;
    logic [8:0]   w_cell_idx;
    logic         w_unused;

    // Blue and the low-intensity colour bits carry nothing the checker needs.
    assign w_unused = ^{vga_in[6:4], vga_in[2]};

    // Syncs are stored already normalised to active-high, so a cleared register reads idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_hs_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_pix     <= 2'b00;
        end else begin
            r_hs      <= vga_in[7] ^ SyncInv;
            r_vs      <= vga_in[3] ^ SyncInv;
            r_hs_prev <= r_hs;
            r_vs_prev <= r_vs;
            r_pix     <= vga_in[1:0];
        end
    end

    assign w_hs_edge  = r_hs & ~r_hs_prev;
    assign w_vs_edge  = r_vs & ~r_vs_prev;
    assign w_vs_pend  = r_vs_pending | w_vs_edge;
    assign w_line_err = w_hs_edge && (r_state != StSearch) && (r_h_cnt != HLast);
    assign w_v_last   = (r_v_cnt == VLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_vs_pending <= 1'b0;
        end else begin
            if (w_hs_edge) begin
                r_h_cnt <= '0;
            end else if (r_h_cnt != 10'h3ff) begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
            // A vsync edge coinciding with hsync restarts the frame on that very line.
            if (w_hs_edge && w_vs_pend) begin
                r_v_cnt      <= '0;
                r_vs_pending <= 1'b0;
            end else begin
                r_vs_pending <= w_vs_pend;
                if (w_hs_edge && r_v_cnt != 10'h3ff) begin
                    r_v_cnt <= r_v_cnt + 10'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_commit  = 1'b0;
        w_drop    = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            StSearch: begin
                if (w_vs_edge) w_state_d = StAlign;
            end
            StAlign: begin
                if (w_vs_edge && !r_align_err && !w_line_err && w_v_last) w_state_d = StCapture;
            end
            StCapture: begin
                if (w_line_err) begin
                    w_state_d = StSearch;
                    w_abort   = 1'b1;
                end else if (w_vs_edge) begin
                    w_commit = w_v_last;
                    w_drop   = ~w_v_last;
                end
            end
            default: w_state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StSearch;
            r_align_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // Each vsync starts a fresh measurement window for the alignment check.
            if (w_vs_edge) begin
                r_align_err <= 1'b0;
            end else if (w_line_err) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign w_hx       = r_h_cnt - HStart;
    assign w_vy       = r_v_cnt - VStart;
    assign w_sample   = (r_h_cnt >= HStart) && (w_hx[9:8] == 2'b00) && (w_hx[2:0] == SubOfs) &&
                        (r_v_cnt >= VStart) && (w_vy[9:7] == 3'b000) && (w_vy[2:0] == SubOfs);
    assign w_cell_idx = {w_vy[6:3], w_hx[7:3]};
    assign w_bit      = r_pix[0] & r_pix[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow   <= '0;
            r_live_acc <= '0;
        end else if (w_vs_edge || w_abort) begin
            r_shadow   <= '0;
            r_live_acc <= '0;
        end else if (w_sample) begin
            r_shadow[w_cell_idx] <= w_bit;
            r_live_acc           <= r_live_acc + {9'd0, w_bit};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitmap      <= '0;
            r_live_count  <= '0;
            r_frame_cnt   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_drop  <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_bitmap     <= r_shadow;
                r_live_count <= r_live_acc;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
            end
            r_frame_valid <= w_commit;
            r_frame_drop  <= w_drop;
            r_timing_err  <= r_timing_err | w_abort;
        end
    end

    assign rd_data     = r_bitmap[rd_addr];
    assign live_count  = r_live_count;
    assign frame_cnt   = r_frame_cnt;
    assign frame_valid = r_frame_valid;
    assign frame_drop  = r_frame_drop;
    assign locked      = (r_state == StCapture);
    assign timing_err  = r_timing_err;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a shrunken raster (80x48) so many frames fit;
// a second instance sees active-high syncs and must capture the same board.
module tb_vga_frame_capture;

    localparam int HT  = 80;
    localparam int VT  = 48;
    localparam int HO  = 8;
    localparam int VO  = 4;
    localparam int XO  = 8;
    localparam int YO  = 8;
    localparam int SO  = 3;
    localparam int HSW = 4;
    localparam int VSW = 2;

    logic        clk;
    logic        reset;
    logic [7:0]  vga0, vga1;
    logic [8:0]  rd_addr;
    logic        rd0, rd1;
    logic [9:0]  live0, live1;
    logic [15:0] fcnt0, fcnt1;
    logic        fv0, fv1, fd0, fd1, locked0, locked1, terr0, terr1;

    int n_total = 0;
    int n_bad   = 0;
    int n_fv    = 0;
    int n_fd    = 0;

    vga_frame_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO), .X0(XO), .Y0(YO),
        .SAMPLE_OFS(SO), .SYNC_ACTIVE_LOW(1)
    ) dut0 (
        .clk(clk), .reset(reset), .vga_in(vga0), .rd_addr(rd_addr), .rd_data(rd0),
        .live_count(live0), .frame_cnt(fcnt0), .frame_valid(fv0), .frame_drop(fd0),
        .locked(locked0), .timing_err(terr0)
    );

    vga_frame_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO), .X0(XO), .Y0(YO),
        .SAMPLE_OFS(SO), .SYNC_ACTIVE_LOW(0)
    ) dut1 (
        .clk(clk), .reset(reset), .vga_in(vga1), .rd_addr(rd_addr), .rd_data(rd1),
        .live_count(live1), .frame_cnt(fcnt1), .frame_valid(fv1), .frame_drop(fd1),
        .locked(locked1), .timing_err(terr1)
    );

    initial clk = 1'b0;
    always #1000 clk = ~clk;

    always @(negedge clk) begin
        if (fv0) n_fv <= n_fv + 1;
        if (fd0) n_fd <= n_fd + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Pattern 1: cells (0,0),(5,3),(7,4). Pattern 2: cells (1,1),(7,0).
    function automatic bit cell_on(input int pat, input int cx, input int cy);
        case (pat)
            1: return (cx == 0 && cy == 0) || (cx == 5 && cy == 3) || (cx == 7 && cy == 4);
            2: return (cx == 1 && cy == 1) || (cx == 7 && cy == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Column 0 is driven at h = HO+1 because the DUT counts from the registered hsync edge.
    task automatic set_pins(input int h, input int v, input int pat);
        logic hs, vs, r1, g1, lo, b1;
        int   col, row;
        hs  = (h < HSW);
        vs  = (v < VSW);
        col = h - (HO + 1);
        row = v - VO;
        r1  = (col >= 0) && (row >= 0);
        g1  = r1 && col >= XO && row >= YO && cell_on(pat, (col - XO) / 8, (row - YO) / 8);
        lo  = r1 && col >= XO && row >= YO && (col - XO) / 8 == 2 && (row - YO) / 8 == 2;
        b1  = (h % 2 == 1);
        vga0 = {~hs, 1'b0, lo, lo, ~vs, b1, g1, r1};
        vga1 = { hs, 1'b0, lo, lo,  vs, b1, g1, r1};
    endtask

    task automatic drive_lines(input int v_first, input int v_last, input int short_v,
                               input int pat);
        int len;
        for (int v = v_first; v <= v_last; v++) begin
            len = (v == short_v) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                @(posedge clk);
                #1;
                set_pins(h, v, pat);
                if (short_v >= 0 && v == short_v + 1) begin
                    if (h == 1) check_eq("locked_in_edge_cycle", locked0, 1);
                    if (h == 2) check_eq("unlocked_after_edge", locked0, 0);
                    if (h == 3) check_eq("timing_err_set", terr0, 1);
                end
            end
        end
    endtask

    task automatic check_map(input int pat);
        for (int a = 0; a < 512; a++) begin
            rd_addr = 9'(a);
            #1;
            check_eq($sformatf("map0[%0d]", a), rd0, cell_on(pat, a % 32, a / 32));
            check_eq($sformatf("map1[%0d]", a), rd1, cell_on(pat, a % 32, a / 32));
        end
    endtask

    task automatic spot(input int a, input bit exp);
        rd_addr = 9'(a);
        #1;
        check_eq($sformatf("rd_data[%0d]", a), rd0, exp);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_locked"}, {locked1, locked0}, 0);
        check_eq({tag, "_terr"}, {terr1, terr0}, 0);
        check_eq({tag, "_fcnt"}, {fcnt1, fcnt0}, 0);
        check_eq({tag, "_live"}, {live1, live0}, 0);
        check_eq({tag, "_pulses"}, {fv1, fv0, fd1, fd0}, 0);
        check_eq({tag, "_rd"}, {rd1, rd0}, 0);
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        vga0    = '0;
        vga1    = '0;
        repeat (20) begin
            @(posedge clk);
            #1;
            vga0    = 8'($urandom);
            vga1    = 8'($urandom);
            rd_addr = 9'($urandom);
        end
        check_zero("in_reset");
        @(posedge clk);
        #1;
        vga0    = 8'h88;
        vga1    = 8'h00;
        reset   = 1'b0;
        rd_addr = '0;
        repeat (50) @(posedge clk);
        #1;
        check_zero("idle");

        // Lock and first commit.
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f1_locked", locked0, 0);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f2_locked", locked0, 1);
        check_eq("f2_fcnt", fcnt0, 0);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f3_nvalid", n_fv, 1);
        check_eq("f3_fcnt", fcnt0, 1);
        check_eq("f3_live", live0, 3);
        check_eq("f3_fcnt1", fcnt1, 1);
        check_eq("f3_live1", live1, 3);
        check_eq("f3_locked1", locked1, 1);
        check_map(1);

        // Short frame (47 lines) is dropped; the following good frame commits.
        drive_lines(0, VT - 2, -1, 2);
        drive_lines(0, VT - 1, -1, 2);
        check_eq("f5_ndrop", n_fd, 1);
        check_eq("f5_nvalid", n_fv, 2);
        check_eq("f5_fcnt", fcnt0, 2);
        check_eq("f5_live", live0, 3);
        check_eq("f5_locked", locked0, 1);
        spot(101, 1'b1);
        spot(33, 1'b0);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f6_fcnt", fcnt0, 3);
        check_eq("f6_live", live0, 2);
        check_eq("f6_ndrop", n_fd, 1);
        check_eq("f6_terr", terr0, 0);
        spot(33, 1'b1);
        spot(7, 1'b1);
        spot(0, 1'b0);

        // One 79-clock line while locked.
        drive_lines(0, VT - 1, 20, 1);
        check_eq("f7_locked", locked0, 0);
        check_eq("f7_fcnt", fcnt0, 4);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f8_locked", locked0, 0);
        check_eq("f8_fcnt", fcnt0, 4);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f9_locked", locked0, 1);
        check_eq("f9_terr", terr0, 1);
        check_eq("f9_fcnt", fcnt0, 4);
        check_eq("f9_nvalid", n_fv, 4);

        // Asynchronous reset in the middle of a captured frame.
        drive_lines(0, 9, -1, 1);
        spot(0, 1'b1);
        #9;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        #5;
        reset = 1'b0;
        drive_lines(10, VT - 1, -1, 1);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f11_locked", locked0, 0);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f12_locked", locked0, 1);
        check_eq("f12_fcnt", fcnt0, 0);
        drive_lines(0, VT - 1, -1, 1);
        check_eq("f13_fcnt", fcnt0, 1);
        check_eq("f13_live", live0, 3);
        check_eq("f13_terr", terr0, 0);
        spot(135, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
